// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch: state encoding, digit maxima
// and the layout of the six-digit display word.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_STOPPED  = 2'd0,
      ST_RUNNING  = 2'd1,
      ST_LAP_HELD = 2'd2
   } sw_state_t;

   localparam int unsigned CS_MAX   = 99;
   localparam int unsigned SEC_MAX  = 59;
   localparam int unsigned MIN_MAX  = 59;

   localparam int unsigned PAIR_W   = 8;
   localparam int unsigned DIGITS_W = 24;
   localparam int unsigned CS_LSB   = 0;
   localparam int unsigned SEC_LSB  = 8;
   localparam int unsigned MIN_LSB  = 16;

   // Packs a decimal value 0..99 into a two-digit BCD byte.
   function automatic logic [7:0] bcd_pair_of(input int unsigned v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

endpackage

// File: rtl/bcd_digit_pair.sv
// Two-digit BCD counter that wraps at MAX; carry_out flags the enabled step
// that wraps, so pairs chain into a multi-digit counter.
module bcd_digit_pair
   import stopwatch_pkg::*;
#(
   parameter int unsigned MAX = 99
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_enable,
   input  logic              i_clear,
   output logic              o_carry_out_c,
   output logic [PAIR_W-1:0] o_value
);

   localparam logic [PAIR_W-1:0] MAX_BCD = bcd_pair_of(MAX);

   logic [PAIR_W-1:0] r_value;
   logic [PAIR_W-1:0] w_next;
   logic              w_at_max;

   assign w_at_max      = (r_value == MAX_BCD);
   assign o_carry_out_c = i_enable && w_at_max;
   assign o_value       = r_value;

   // Next value: clear dominates, otherwise BCD increment with wrap at MAX.
   always_comb begin
      w_next = r_value;
      if (i_clear) begin
         w_next = '0;
      end else if (i_enable) begin
         if (w_at_max) begin
            w_next = '0;
         end else if (r_value[3:0] == 4'd9) begin
            w_next = {r_value[7:4] + 4'd1, 4'd0};
         end else begin
            w_next = {r_value[7:4], r_value[3:0] + 4'd1};
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_value <= '0;
      end else begin
         r_value <= w_next;
      end
   end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS.cc BCD stopwatch: prescaler, run/lap/stop FSM, lap freeze register and
// sticky wrap flag, driven by debounced toggle levels already in the CLK domain.
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 1_000_000,
   parameter int unsigned PRE_WIDTH = 20
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                RUN,
   input  logic                LAP,
   input  logic                CLEAR,
   output logic [DIGITS_W-1:0] DIGITS,
   output logic                RUNNING,
   output logic                LAP_ACTIVE,
   output logic                OVERFLOW,
   output logic                TICK_OUT
);

   localparam logic [PRE_WIDTH-1:0] PRE_LAST = PRE_WIDTH'(TICK_DIV - 1);

   sw_state_t             r_state;
   sw_state_t             w_state_nxt;
   logic                  r_primed;
   logic                  r_run, r_run_d;
   logic                  r_lap, r_lap_d;
   logic                  r_clr, r_clr_d;
   logic [PRE_WIDTH-1:0]  r_pre;
   logic                  r_tick;
   logic                  r_ovf;
   logic [DIGITS_W-1:0]   r_lap_val;

   logic                  w_run_rise, w_run_fall;
   logic                  w_lap_rise, w_lap_fall;
   logic                  w_clr_rise;
   logic                  w_do_clear, w_lap_load, w_counting, w_tick;
   logic                  w_cs_carry, w_sec_carry, w_min_carry;
   logic [PAIR_W-1:0]     w_cs, w_sec, w_min;
   logic [DIGITS_W-1:0]   w_live;

   // First cycle after reset loads both copies with the live level, so a
   // level held through reset release never looks like an edge.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_primed <= 1'b0;
         r_run    <= 1'b0;
         r_run_d  <= 1'b0;
         r_lap    <= 1'b0;
         r_lap_d  <= 1'b0;
         r_clr    <= 1'b0;
         r_clr_d  <= 1'b0;
      end else begin
         r_primed <= 1'b1;
         r_run    <= RUN;
         r_lap    <= LAP;
         r_clr    <= CLEAR;
         r_run_d  <= r_primed ? r_run : RUN;
         r_lap_d  <= r_primed ? r_lap : LAP;
         r_clr_d  <= r_primed ? r_clr : CLEAR;
      end
   end

   assign w_run_rise =  r_run & ~r_run_d;
   assign w_run_fall = ~r_run &  r_run_d;
   assign w_lap_rise =  r_lap & ~r_lap_d;
   assign w_lap_fall = ~r_lap &  r_lap_d;
   assign w_clr_rise =  r_clr & ~r_clr_d;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state <= ST_STOPPED;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // RUN fall has priority over LAP activity in both counting states.
   always_comb begin
      w_state_nxt = r_state;
      w_do_clear  = 1'b0;
      w_lap_load  = 1'b0;
      w_counting  = 1'b0;
      case (r_state)
         ST_STOPPED: begin
            w_do_clear = w_clr_rise;
            if (w_run_rise) begin
               w_state_nxt = ST_RUNNING;
            end
         end
         ST_RUNNING: begin
            w_counting = 1'b1;
            if (w_run_fall) begin
               w_state_nxt = ST_STOPPED;
            end else if (w_lap_rise) begin
               w_state_nxt = ST_LAP_HELD;
               w_lap_load  = 1'b1;
            end
         end
         ST_LAP_HELD: begin
            w_counting = 1'b1;
            if (w_run_fall) begin
               w_state_nxt = ST_STOPPED;
            end else if (w_lap_fall) begin
               w_state_nxt = ST_RUNNING;
            end
         end
         default: begin
            w_state_nxt = ST_STOPPED;
         end
      endcase
   end

   assign w_tick = w_counting && (r_pre == PRE_LAST);

   // Prescaler holds while stopped so a partial hundredth survives a pause.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_pre <= '0;
      end else if (w_do_clear) begin
         r_pre <= '0;
      end else if (w_counting) begin
         r_pre <= w_tick ? '0 : r_pre + PRE_WIDTH'(1);
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_tick    <= 1'b0;
         r_ovf     <= 1'b0;
         r_lap_val <= '0;
      end else begin
         r_tick <= w_tick;
         if (w_do_clear) begin
            r_ovf     <= 1'b0;
            r_lap_val <= '0;
         end else begin
            if (w_min_carry) begin
               r_ovf <= 1'b1;
            end
            if (w_lap_load) begin
               r_lap_val <= w_live;
            end
         end
      end
   end

   bcd_digit_pair #(.MAX(CS_MAX)) u_cs (
      .i_clk         (CLK),
      .i_rst_n       (RESET_N),
      .i_enable      (w_tick),
      .i_clear       (w_do_clear),
      .o_carry_out_c (w_cs_carry),
      .o_value       (w_cs)
   );

   bcd_digit_pair #(.MAX(SEC_MAX)) u_sec (
      .i_clk         (CLK),
      .i_rst_n       (RESET_N),
      .i_enable      (w_cs_carry),
      .i_clear       (w_do_clear),
      .o_carry_out_c (w_sec_carry),
      .o_value       (w_sec)
   );

   bcd_digit_pair #(.MAX(MIN_MAX)) u_min (
      .i_clk         (CLK),
      .i_rst_n       (RESET_N),
      .i_enable      (w_sec_carry),
      .i_clear       (w_do_clear),
      .o_carry_out_c (w_min_carry),
      .o_value       (w_min)
   );

   assign w_live[CS_LSB  +: PAIR_W] = w_cs;
   assign w_live[SEC_LSB +: PAIR_W] = w_sec;
   assign w_live[MIN_LSB +: PAIR_W] = w_min;

   assign DIGITS     = (r_state == ST_LAP_HELD) ? r_lap_val : w_live;
   assign RUNNING    = (r_state != ST_STOPPED);
   assign LAP_ACTIVE = (r_state == ST_LAP_HELD);
   assign OVERFLOW   = r_ovf;
   assign TICK_OUT   = r_tick;

endmodule
